// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the gshare branch predictor: prediction
// request/response, training report and statistics.
interface branch_predictor_if #(
  parameter int PC_W   = 12,
  parameter int HIST_W = 6
);
  logic              ready;
  logic              pred_req;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_history;
  logic              train_valid;
  logic [PC_W-1:0]   train_pc;
  logic [HIST_W-1:0] train_history;
  logic              train_taken;
  logic              train_mispredicted;
  logic [15:0]       stat_branches;
  logic [15:0]       stat_mispredicts;

  modport master (
    input  ready, pred_valid, pred_taken, pred_history,
           stat_branches, stat_mispredicts,
    output pred_req, pred_pc, train_valid, train_pc, train_history,
           train_taken, train_mispredicted
  );

  modport slave (
    output ready, pred_valid, pred_taken, pred_history,
           stat_branches, stat_mispredicts,
    input  pred_req, pred_pc, train_valid, train_pc, train_history,
           train_taken, train_mispredicted
  );
endinterface

// File: rtl/branch_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit
// counters, swept to weakly-not-taken after every reset before use.
module branch_predictor #(
  parameter int PC_W   = 12,
  parameter int HIST_W = 6
) (
  input logic                CLK,
  input logic                RES,
  branch_predictor_if.slave  bus
);
  localparam int ENTRIES = 1 << HIST_W;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  logic [0:0]        state;
  logic [HIST_W-1:0] init_idx;
  logic [HIST_W-1:0] ghr;
  logic [1:0]        pht [ENTRIES];

  logic [HIST_W-1:0] pred_idx;
  logic [HIST_W-1:0] train_idx;
  logic              run;
  logic              pred_fire;
  logic              train_fire;
  logic              pred_dir;
  logic [1:0]        train_ctr;
  logic [1:0]        train_next;

  logic              pred_valid_q;
  logic              pred_taken_q;
  logic [HIST_W-1:0] pred_history_q;
  logic [15:0]       branches_q;
  logic [15:0]       mispredicts_q;

  // Only the low PC bits take part in the index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[PC_W-1:HIST_W], bus.train_pc[PC_W-1:HIST_W]};

  assign run        = (state == ST_RUN);
  assign pred_fire  = run && bus.pred_req;
  assign train_fire = run && bus.train_valid;
  assign pred_idx   = bus.pred_pc[HIST_W-1:0] ^ ghr;
  assign train_idx  = bus.train_pc[HIST_W-1:0] ^ bus.train_history;
  assign pred_dir   = pht[pred_idx][1];
  assign train_ctr  = pht[train_idx];

  always_comb begin
    train_next = train_ctr;
    if (bus.train_taken) begin
      if (train_ctr != 2'b11) train_next = train_ctr + 2'b01;
    end else begin
      if (train_ctr != 2'b00) train_next = train_ctr - 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else if (state == ST_INIT) begin
      init_idx <= init_idx + HIST_W'(1);
      if (init_idx == HIST_W'(ENTRIES - 1)) state <= ST_RUN;
    end
  end

  // NOTE: the counter table has no reset branch; the INIT sweep is what gives
  // it defined contents, and leaving it out keeps the array mappable to RAM.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      if (state == ST_INIT)  pht[init_idx]  <= 2'b01;
      else if (train_fire)   pht[train_idx] <= train_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      ghr            <= '0;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_history_q <= '0;
      branches_q     <= '0;
      mispredicts_q  <= '0;
    end else begin
      pred_valid_q   <= pred_fire;
      pred_taken_q   <= pred_fire && pred_dir;
      pred_history_q <= pred_fire ? ghr : '0;

      // A resolved mispredict wins over the speculative shift of the same cycle.
      if (train_fire && bus.train_mispredicted)
        ghr <= {bus.train_history[HIST_W-2:0], bus.train_taken};
      else if (pred_fire)
        ghr <= {ghr[HIST_W-2:0], pred_dir};

      if (train_fire) begin
        if (branches_q != STAT_MAX) branches_q <= branches_q + 16'd1;
        if (bus.train_mispredicted && mispredicts_q != STAT_MAX)
          mispredicts_q <= mispredicts_q + 16'd1;
      end
    end
  end

  assign bus.ready            = run;
  assign bus.pred_valid       = pred_valid_q;
  assign bus.pred_taken       = pred_taken_q;
  assign bus.pred_history     = pred_history_q;
  assign bus.stat_branches    = branches_q;
  assign bus.stat_mispredicts = mispredicts_q;
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: PC_W, default 12, width of program-counter inputs.
REQ-002 Parameter: HIST_W, default 6, global-history width; pattern table holds 2^HIST_W 2-bit counters.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RES  input  1  synchronous reset, active-high.
REQ-005 ready  output  1  high when table initialisation is complete and requests are accepted.
REQ-006 pred_req  input  1  fetch stage requests a prediction this cycle.
REQ-007 pred_pc  input  PC_W  PC of the instruction being predicted.
REQ-008 pred_valid  output  1  prediction result valid this cycle.
REQ-009 pred_taken  output  1  predicted direction, 1 = taken.
REQ-010 pred_history  output  HIST_W  global history used to form the prediction index.
REQ-011 train_valid  input  1  execute stage reports a resolved branch.
REQ-012 train_pc  input  PC_W  PC of the resolved branch.
REQ-013 train_history  input  HIST_W  pred_history returned with that branch's prediction.
REQ-014 train_taken  input  1  actual branch outcome.
REQ-015 train_mispredicted  input  1  predicted direction differed from actual outcome.
REQ-016 stat_branches  output  16  count of trained branches, saturating.
REQ-017 stat_mispredicts  output  16  count of mispredicted branches, saturating.

Function
REQ-018 Two-state FSM: INIT and RUN; ready=1 only in RUN.
REQ-019 INIT: one table entry per cycle written to 2'b01 (weakly not-taken), index 0 upward; after entry 2^HIST_W-1 is written, FSM enters RUN on the next cycle.
REQ-020 In INIT, pred_req and train_valid are ignored: no pred_valid, no table/GHR/stat change.
REQ-021 Prediction index = pred_pc[HIST_W-1:0] XOR GHR; training index = train_pc[HIST_W-1:0] XOR train_history.
REQ-022 Prediction latency is one cycle: pred_req in RUN at cycle N gives pred_valid=1 at N+1 with pred_taken = counter[idx][1] read at N and pred_history = GHR at N.
REQ-023 pred_valid=0 in every cycle not following an accepted pred_req; one prediction per cycle, fully pipelined.
REQ-024 Speculative history: an accepted pred_req sets GHR <= {GHR[HIST_W-2:0], predicted direction}.
REQ-025 Training: counter at training index increments if train_taken, else decrements, saturating at 2'b11 and 2'b00.
REQ-026 Each accepted train_valid increments stat_branches; if train_mispredicted, also increments stat_mispredicts; both hold at 16'hFFFF.
REQ-027 Mispredict recovery: train_valid with train_mispredicted sets GHR <= {train_history[HIST_W-2:0], train_taken}, overriding any same-cycle speculative update.
REQ-028 Same-cycle predict and train to one index: the prediction uses the pre-update counter value.
REQ-029 pred_taken and pred_history are 0 whenever pred_valid=0.

Reset
REQ-030 RES=1 at an edge: FSM->INIT, init index 0, GHR 0, pred_valid 0, pred_taken 0, pred_history 0, ready 0, stat_branches 0, stat_mispredicts 0.
REQ-031 RES asserted mid-operation discards any pending prediction (no pred_valid next cycle) and restarts the full INIT sweep.
REQ-032 Table contents are defined only by the INIT sweep, not by RES directly.

Verification
REQ-033 RES high 2 cycles then low, pred_req held high -> ready=0 and pred_valid=0 for 64 cycles, ready=1 on cycle 64 after RES low.
REQ-034 After init, GHR=0: train pc=0x005 history=0 taken=1 twice, then pred_req pc=0x005 -> pred_taken=1, pred_history=6'h00; next prediction shows pred_history=6'h01.
REQ-035 Train pc=0x005 history=0 not-taken 4 times from 2'b11 -> counter 2'b00; pred_req pc=0x005 at GHR=0 -> pred_taken=0.
REQ-036 Train mispredicted=1, history=6'h15, taken=1 with same-cycle pred_req -> that prediction shows pre-restore GHR; next prediction shows pred_history=6'h2B; stat_mispredicts=1.
REQ-037 70000 train_valid pulses with mispredicted=1 -> stat_branches=16'hFFFF, stat_mispredicts=16'hFFFF, no wrap.
REQ-038 RES pulsed one cycle the cycle after pred_req in RUN -> no pred_valid, GHR=0, stats=0, ready=0 for 64 cycles then 1.
